// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the PIC control sequencer.
//   - init_state_e : initialisation FSM states (ICW1..ICW4 sequencing)
//   - OCW2_*       : OCW2 command codes carried in din[7:5]
//   - ICW1_*       : bit positions inside the ICW1 byte
//   - INTA_*       : intAcounter encodings seen by the interrupt block
//   - is_icw1()    : ICW1 write decode (a0=0 with din[4] set)
package pic_pkg;

  typedef enum logic [2:0] {
    ST_UNINIT    = 3'd0,
    ST_WAIT_ICW2 = 3'd1,
    ST_WAIT_ICW3 = 3'd2,
    ST_WAIT_ICW4 = 3'd3,
    ST_READY     = 3'd4
  } init_state_e;

  localparam logic [2:0] OCW2_NSEOI        = 3'b001;
  localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;

  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SEL  = 4;

  localparam logic [1:0] INTA_IDLE   = 2'd0;
  localparam logic [1:0] INTA_FIRST  = 2'd1;
  localparam logic [1:0] INTA_SECOND = 2'd2;

  // ICW1 is recognised in every state, so the decode lives here.
  function automatic logic is_icw1(input logic wr, input logic sel, input logic [7:0] d);
    return wr & ~sel & d[ICW1_SEL];
  endfunction

endpackage

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: two-pulse INTA handshake.
//   clk, rst_n    : clock, synchronous active-low reset
//   enable        : sequence allowed (initialisation complete)
//   clear         : abort the sequence (ICW1 written)
//   inta_n        : acknowledge from CPU, already synchronised, active-low
//   base          : vector base bits T7..T3
//   isr_level     : in-service level supplied by the interrupt block
//   inta_count    : 0 idle, 1 after first INTA, 2 after second INTA
//   dout, dout_en : vector byte and its valid flag
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             inta_n,
  input  logic [VEC_W-4:0] base,
  input  logic [2:0]       isr_level,
  output logic [1:0]       inta_count,
  output logic [VEC_W-1:0] dout,
  output logic             dout_en
);

  logic inta_prev;
  logic fall;
  logic rise;

  // Edges are taken against the previous-cycle sample so the response lands one cycle later.
  assign fall = inta_prev & ~inta_n;
  assign rise = ~inta_prev & inta_n;

  // Edge history, INTA count and vector output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inta_prev  <= 1'b1;
      inta_count <= INTA_IDLE;
      dout       <= {VEC_W{1'b0}};
      dout_en    <= 1'b0;
    end else begin
      inta_prev <= inta_n;
      if (clear || !enable) begin
        inta_count <= INTA_IDLE;
        dout_en    <= 1'b0;
      end else begin
        case (inta_count)
          INTA_IDLE: begin
            if (fall) inta_count <= INTA_FIRST;
          end
          INTA_FIRST: begin
            // Rises between the two pulses leave the count alone.
            if (fall) begin
              inta_count <= INTA_SECOND;
              dout       <= {base, isr_level};
              dout_en    <= 1'b1;
            end
          end
          INTA_SECOND: begin
            // dout is held; only the valid flag drops.
            if (rise) begin
              inta_count <= INTA_IDLE;
              dout_en    <= 1'b0;
            end
          end
          default: begin
            inta_count <= INTA_IDLE;
            dout_en    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pic_control_sequencer.sv
// pic_control_sequencer: decodes CPU writes into ICW1-ICW4 / OCW1 / OCW2 and
// drives the interrupt block configuration; hosts the INTA sequencer.
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_en, a0, din      : one-cycle CPU write strobe, register select, data
//   inta_n              : interrupt acknowledge (active-low, synchronised)
//   int_req, isr_level  : INT and in-service level from the interrupt block
//   int_out             : INT to CPU
//   inta_count          : intAcounter to the interrupt block
//   level_or_edge, mask : LTIM and interrupt mask
//   rotate_set/reset    : rotation mode level / clear pulse
//   aeoi, eoi           : automatic-EOI level / non-specific EOI pulse
//   dout, dout_en       : vector byte and valid
//   init_done           : initialisation complete
module pic_control_sequencer
  import pic_pkg::*;
#(
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             a0,
  input  logic [VEC_W-1:0] din,
  input  logic             inta_n,
  input  logic             int_req,
  input  logic [2:0]       isr_level,
  output logic             int_out,
  output logic [1:0]       inta_count,
  output logic             level_or_edge,
  output logic [VEC_W-1:0] mask,
  output logic             rotate_set,
  output logic             rotate_reset,
  output logic             aeoi,
  output logic             eoi,
  output logic [VEC_W-1:0] dout,
  output logic             dout_en,
  output logic             init_done
);

  init_state_e      state;
  logic             sngl;
  logic             ic4;
  logic [VEC_W-4:0] base;
  logic             icw1_wr;

  assign icw1_wr = is_icw1(wr_en, a0, din);

  // Initialisation FSM and configuration registers; ICW1 overrides any other decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_UNINIT;
      sngl          <= 1'b0;
      ic4           <= 1'b0;
      base          <= {(VEC_W-3){1'b0}};
      level_or_edge <= 1'b0;
      mask          <= {VEC_W{1'b1}};
      aeoi          <= 1'b0;
      rotate_set    <= 1'b0;
      rotate_reset  <= 1'b0;
      eoi           <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      eoi          <= 1'b0;
      rotate_reset <= 1'b0;
      if (icw1_wr) begin
        level_or_edge <= din[ICW1_LTIM];
        sngl          <= din[ICW1_SNGL];
        ic4           <= din[ICW1_IC4];
        mask          <= {VEC_W{1'b0}};
        aeoi          <= 1'b0;
        rotate_set    <= 1'b0;
        init_done     <= 1'b0;
        state         <= ST_WAIT_ICW2;
      end else if (wr_en) begin
        case (state)
          ST_WAIT_ICW2: begin
            if (a0) begin
              base <= din[VEC_W-1:3];
              if (!sngl) begin
                state <= ST_WAIT_ICW3;
              end else if (ic4) begin
                state <= ST_WAIT_ICW4;
              end else begin
                state     <= ST_READY;
                init_done <= 1'b1;
              end
            end
          end
          ST_WAIT_ICW3: begin
            // No cascade support: the ICW3 byte is accepted and dropped.
            if (a0) begin
              if (ic4) begin
                state <= ST_WAIT_ICW4;
              end else begin
                state     <= ST_READY;
                init_done <= 1'b1;
              end
            end
          end
          ST_WAIT_ICW4: begin
            if (a0) begin
              aeoi      <= din[1];
              state     <= ST_READY;
              init_done <= 1'b1;
            end
          end
          ST_READY: begin
            if (a0) begin
              mask <= din;
            end else if (din[4:3] == 2'b00) begin
              case (din[7:5])
                OCW2_NSEOI:        eoi <= 1'b1;
                OCW2_ROT_NSEOI: begin
                  eoi        <= 1'b1;
                  rotate_set <= 1'b1;
                end
                OCW2_ROT_AEOI_SET: rotate_set <= 1'b1;
                OCW2_ROT_AEOI_CLR: begin
                  rotate_set   <= 1'b0;
                  rotate_reset <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  pic_inta_sequencer #(.VEC_W(VEC_W)) u_inta (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (init_done),
    .clear      (icw1_wr),
    .inta_n     (inta_n),
    .base       (base),
    .isr_level  (isr_level),
    .inta_count (inta_count),
    .dout       (dout),
    .dout_en    (dout_en)
  );

  // INT is masked off while an acknowledge is in progress or before init.
  assign int_out = int_req & init_done & (inta_count == INTA_IDLE);

endmodule

// File: tb/tb_pic_control_sequencer.sv
// Testbench for pic_control_sequencer: directed writes and INTA pulses, a
// reference model driven by the ICW/OCW/INTA rules, a per-cycle compare and
// a set of literal spot checks.
module tb_pic_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       a0;
  logic [7:0] din;
  logic       inta_n;
  logic       int_req;
  logic [2:0] isr_level;
  logic       int_out;
  logic [1:0] inta_count;
  logic       level_or_edge;
  logic [7:0] mask;
  logic       rotate_set;
  logic       rotate_reset;
  logic       aeoi;
  logic       eoi;
  logic [7:0] dout;
  logic       dout_en;
  logic       init_done;

  int n_checks = 0;
  int n_fails  = 0;

  pic_control_sequencer #(.VEC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .a0(a0), .din(din),
    .inta_n(inta_n), .int_req(int_req), .isr_level(isr_level),
    .int_out(int_out), .inta_count(inta_count), .level_or_edge(level_or_edge),
    .mask(mask), .rotate_set(rotate_set), .rotate_reset(rotate_reset),
    .aeoi(aeoi), .eoi(eoi), .dout(dout), .dout_en(dout_en), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         pend[$];      // ICW numbers still owed after ICW1
  logic       m_done, m_lte, m_aeoi, m_rot, m_eoi, m_rrst, m_den, m_prev;
  logic [7:0] m_mask, m_dout;
  logic [4:0] m_base;
  int         m_cnt;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic fell, rose, icw1, was_done;
    int w;
    if (!rst_n) begin
      pend.delete();
      m_done = 1'b0; m_lte = 1'b0; m_aeoi = 1'b0; m_rot = 1'b0; m_eoi = 1'b0;
      m_rrst = 1'b0; m_den = 1'b0; m_prev = 1'b1; m_mask = 8'hFF; m_dout = 8'h00;
      m_base = 5'd0; m_cnt = 0;
    end else begin
      fell = m_prev & ~inta_n;
      rose = ~m_prev & inta_n;
      m_prev = inta_n;
      was_done = m_done;
      m_eoi = 1'b0;
      m_rrst = 1'b0;
      icw1 = wr_en && !a0 && din[4];
      if (icw1) begin
        pend.delete();
        pend.push_back(2);
        if (!din[1]) pend.push_back(3);
        if (din[0]) pend.push_back(4);
        m_lte = din[3]; m_mask = 8'h00; m_aeoi = 1'b0; m_rot = 1'b0; m_done = 1'b0;
      end else if (wr_en) begin
        if (pend.size() > 0) begin
          if (a0) begin
            w = pend.pop_front();
            if (w == 2) m_base = din[7:3];
            if (w == 4) m_aeoi = din[1];
            if (pend.size() == 0) m_done = 1'b1;
          end
        end else if (m_done) begin
          if (a0) m_mask = din;
          else if (din[4:3] == 2'b00) begin
            if (din[7:5] == 3'd1) m_eoi = 1'b1;
            else if (din[7:5] == 3'd5) begin m_eoi = 1'b1; m_rot = 1'b1; end
            else if (din[7:5] == 3'd4) m_rot = 1'b1;
            else if (din[7:5] == 3'd0) begin m_rot = 1'b0; m_rrst = 1'b1; end
          end
        end
      end
      if (icw1 || !was_done) begin
        m_cnt = 0; m_den = 1'b0;
      end else if (fell && m_cnt == 0) begin
        m_cnt = 1;
      end else if (fell && m_cnt == 1) begin
        m_cnt = 2; m_dout = {m_base, isr_level}; m_den = 1'b1;
      end else if (rose && m_cnt == 2) begin
        m_cnt = 0; m_den = 1'b0;
      end
    end
  endtask

  // Model advances on each rising edge; DUT compared 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("int_out",       {7'd0, int_out},       {7'd0, int_req & m_done & (m_cnt == 0)});
      chk("inta_count",    {6'd0, inta_count},    8'(m_cnt));
      chk("level_or_edge", {7'd0, level_or_edge}, {7'd0, m_lte});
      chk("mask",          mask,                  m_mask);
      chk("rotate_set",    {7'd0, rotate_set},    {7'd0, m_rot});
      chk("rotate_reset",  {7'd0, rotate_reset},  {7'd0, m_rrst});
      chk("aeoi",          {7'd0, aeoi},          {7'd0, m_aeoi});
      chk("eoi",           {7'd0, eoi},           {7'd0, m_eoi});
      chk("dout",          dout,                  m_dout);
      chk("dout_en",       {7'd0, dout_en},       {7'd0, m_den});
      chk("init_done",     {7'd0, init_done},     {7'd0, m_done});
    end
  end

  task automatic wr(input logic sel, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; a0 = sel; din = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_inta(input logic v);
    @(negedge clk);
    inta_n = v;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; a0 = 1'b0; din = 8'h00;
    inta_n = 1'b1; int_req = 1'b0; isr_level = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_mask",  mask,                 8'hFF);
    chk("rst_done",  {7'd0, init_done},    8'h00);
    chk("rst_count", {6'd0, inta_count},   8'h00);
    rst_n = 1'b1;

    // INTA pulses before initialisation are ignored
    set_inta(1'b0); set_inta(1'b1); set_inta(1'b0); set_inta(1'b1);
    @(negedge clk);
    chk("uninit_count", {6'd0, inta_count}, 8'h00);

    // ICW1=13 (single, IC4), ICW2=40, ICW4=03
    wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h03);
    chk("init_done1", {7'd0, init_done},     8'h01);
    chk("aeoi1",      {7'd0, aeoi},          8'h01);
    chk("ltim1",      {7'd0, level_or_edge}, 8'h00);
    chk("mask1",      mask,                  8'h00);

    // OCW1 then OCW2 non-specific EOI
    wr(1'b1, 8'hA5);
    chk("ocw1_mask", mask, 8'hA5);
    wr(1'b0, 8'h20);
    chk("eoi_hi", {7'd0, eoi}, 8'h01);
    @(negedge clk);
    chk("eoi_lo", {7'd0, eoi}, 8'h00);

    // INTA handshake with base 01000, level 3
    int_req = 1'b1; isr_level = 3'd3;
    #1 chk("int_out_idle", {7'd0, int_out}, 8'h01);
    set_inta(1'b0); @(negedge clk);
    chk("cnt1",     {6'd0, inta_count}, 8'h01);
    chk("int_out1", {7'd0, int_out},    8'h00);
    set_inta(1'b1); set_inta(1'b0); @(negedge clk);
    chk("cnt2",      {6'd0, inta_count}, 8'h02);
    chk("vec",       dout,               8'h43);
    chk("model_vec", m_dout,             8'h43);
    chk("vec_en",    {7'd0, dout_en},    8'h01);
    set_inta(1'b1); @(negedge clk);
    chk("cnt0",     {6'd0, inta_count}, 8'h00);
    chk("vec_off",  {7'd0, dout_en},    8'h00);
    chk("vec_hold", dout,               8'h43);

    // Rotation set / clear, other OCW2 codes, OCW3
    wr(1'b0, 8'h80);
    chk("rot_set", {7'd0, rotate_set}, 8'h01);
    wr(1'b0, 8'h00);
    chk("rot_clr",    {7'd0, rotate_set},   8'h00);
    chk("rot_rst_hi", {7'd0, rotate_reset}, 8'h01);
    @(negedge clk);
    chk("rot_rst_lo", {7'd0, rotate_reset}, 8'h00);
    wr(1'b0, 8'hA0);
    chk("rot_eoi", {6'd0, rotate_set, eoi}, 8'h03);
    wr(1'b0, 8'h60); wr(1'b0, 8'h08);

    // ICW1 during count 1 aborts; INTA ignored until re-init (single, no ICW4)
    set_inta(1'b0); @(negedge clk);
    chk("abort_pre", {6'd0, inta_count}, 8'h01);
    wr(1'b0, 8'h1A);
    chk("abort_cnt",  {6'd0, inta_count},    8'h00);
    chk("abort_done", {7'd0, init_done},     8'h00);
    chk("abort_mask", mask,                  8'h00);
    chk("abort_ltim", {7'd0, level_or_edge}, 8'h01);
    set_inta(1'b1); set_inta(1'b0); set_inta(1'b1);
    wr(1'b1, 8'h88);
    chk("reinit_done", {7'd0, init_done}, 8'h01);
    chk("reinit_aeoi", {7'd0, aeoi},      8'h00);

    // Cascade path through ICW3, with an ignored a0=0 write in between
    wr(1'b0, 8'h11); wr(1'b1, 8'hF8); wr(1'b0, 8'h20); wr(1'b1, 8'h55);
    chk("icw3_wait", {7'd0, init_done}, 8'h00);
    wr(1'b1, 8'h01);
    chk("icw4_done", {7'd0, init_done}, 8'h01);

    // Reset while in count 2
    isr_level = 3'd5;
    set_inta(1'b0); set_inta(1'b1); set_inta(1'b0); @(negedge clk);
    chk("cnt2b", {6'd0, inta_count}, 8'h02);
    chk("vecb",  dout,               8'hFD);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_cnt",  {6'd0, inta_count}, 8'h00);
    chk("rst2_den",  {7'd0, dout_en},    8'h00);
    chk("rst2_mask", mask,               8'hFF);
    chk("rst2_dout", dout,               8'h00);
    rst_n = 1'b1;
    set_inta(1'b1); set_inta(1'b0); @(negedge clk);
    chk("rst2_uninit", {6'd0, inta_count}, 8'h00);
    set_inta(1'b1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pic_control_sequencer.md
Name: pic_control_sequencer

Overview:
Synchronous control block for the PIC. It decodes CPU writes into ICW1-ICW4 and OCW1/OCW2, and drives the configuration inputs of the interrupt block: level_or_edge, mask, set, reset, aeoi and eoi. It also sequences the two-pulse INTA handshake, generating intAcounter and the vector byte. It sits between the bus interface and the interrupt block and consumes that block's INT and ISR outputs.

Parameters:
VEC_W, 8, data/vector bus width (fixed at 8; parameterised only for bench readability)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
wr_en  in  1  one-cycle CPU write strobe
a0  in  1  register select
din  in  8  CPU write data
inta_n  in  1  interrupt acknowledge, active-low, already synchronised to clk
int_req  in  1  INT from interrupt block
isr_level  in  3  ISR output from interrupt block (in-service level)
int_out  out  1  INT to CPU
inta_count  out  2  intAcounter to interrupt block (0 idle, 1 first INTA, 2 second INTA)
level_or_edge  out  1  LTIM; 1 = level-triggered
mask  out  8  interrupt mask register
rotate_set  out  1  automatic-rotation mode, level
rotate_reset  out  1  one-cycle pulse when rotation is cleared
aeoi  out  1  automatic EOI mode, level
eoi  out  1  one-cycle non-specific EOI pulse
dout  out  8  vector byte
dout_en  out  1  vector valid
init_done  out  1  initialisation sequence complete

Behaviour:
- Clocking and reset: one clock domain, clk. rst_n is synchronous and active-low.
- Reset values: init FSM = UNINIT; mask = 8'hFF; level_or_edge, aeoi, rotate_set = 0; pulses = 0; inta_count = 0; dout = 0; dout_en = 0; init_done = 0; vector base = 0.
- Init FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 is a write with a0=0 and din[4]=1. It is accepted in any state, wins over everything else that cycle, and aborts any INTA sequence.
  - Captures LTIM=din[3], SNGL=din[1], IC4=din[0].
  - Sets mask to 8'h00 and clears aeoi and rotate_set.
  - Next state WAIT_ICW2; init_done = 0.
- WAIT_ICW2: a0=1 write stores base = din[7:3].
  - Next state: WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW3: a0=1 write is accepted and the value discarded (no cascade support). Next state: WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4: a0=1 write sets aeoi = din[1]. Next state READY.
- Any write in UNINIT other than ICW1 is ignored. In the WAIT states, a0=0 writes other than ICW1 are ignored.
- init_done = 1 in READY; it updates the cycle after the final ICW.
- READY, a0=1 write (OCW1): mask <= din on the next edge.
- READY, a0=0 with din[4:3]=00 (OCW2); command = din[7:5]:
  - 001: eoi pulse.
  - 101: eoi pulse and rotate_set <= 1.
  - 100: rotate_set <= 1.
  - 000: rotate_set <= 0 and rotate_reset pulse.
  - Other codes are ignored.
- READY, din[4:3]=01 (OCW3): ignored.
- Pulse outputs are high for exactly the one cycle after the write edge.
- INTA edge detection uses a registered inta_prev. fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n. Response is one cycle after the edge.
- INTA sequence (only in READY; ignored otherwise, count stays 0):
  - count 0, on fall: count becomes 1.
  - count 1, on fall: count becomes 2; dout = {base, isr_level}; dout_en = 1 while inta_n is low.
  - count 2, on rise: count becomes 0; dout_en = 0.
  - Rises while count=1 do not change the count.
- int_out = int_req & init_done & (inta_count == 0).
- dout holds its last value after dout_en drops.
- If a write and an INTA edge occur in the same cycle, both are processed independently, except that ICW1 forces inta_count = 0.
- Reset asserted mid-sequence returns every output to its reset value on that edge.

Decomposition:
- Package pic_pkg holds:
  - init-state enum;
  - OCW2 command codes (NSEOI=3'b001, ROT_NSEOI=3'b101, ROT_AEOI_SET=3'b100, ROT_AEOI_CLR=3'b000);
  - ICW1 bit indices (LTIM=3, SNGL=1, IC4=0);
  - INTA count encodings.
- Sub-module pic_inta_sequencer: edge detect, count FSM, vector output; enabled by init_done, with a clear input from ICW1.

Test Plan:
- Reset, then ICW1=8'h13, ICW2=8'h40, ICW4=8'h03 -> init_done=1, aeoi=1, level_or_edge=0, mask=00, ICW3 state skipped.
- Initialised, OCW1 a0=1 din=8'hA5 -> mask=A5 next cycle. Then OCW2 din=8'h20 -> eoi high exactly one cycle.
- int_req=1, isr_level=3, base=01000 -> int_out=1. First inta_n low -> count 1, int_out=0. Second low -> count 2, dout=8'h43, dout_en=1. inta_n high -> count 0.
- OCW2 8'h80 -> rotate_set=1. Then 8'h00 -> rotate_set=0 with a one-cycle rotate_reset.
- ICW1 written while count=1 -> count 0, init_done=0, mask 00. Subsequent INTA pulses are ignored until ICW2 and, if required, ICW4 complete.
- INTA pulses in UNINIT, and rst_n low during count 2 -> count stays/returns 0, dout_en=0, mask=FF.
